// File: rtl/instruction_fifo.sv
// Instruction intake: 80-bit assembly from three host writes, FWFT buffer, decoded head output.

package tpu_pkg;

  typedef struct packed {
    logic [23:0] buffer_addr;
    logic [15:0] acc_addr;
    logic [31:0] length;
    logic [7:0]  opcode;
  } instr_type;

  localparam instr_type INIT_INSTR = '0;

  // Raw 80-bit word to decoded instruction fields
  function automatic instr_type bit_to_instr(input logic [79:0] raw);
    instr_type r;
    r.buffer_addr = raw[79:56];
    r.acc_addr    = raw[55:40];
    r.length      = raw[39:8];
    r.opcode      = raw[7:0];
    return r;
  endfunction

endpackage

module instruction_fifo
  import tpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   lower_word,
  input  logic                          lower_write_en,
  input  logic [31:0]                   middle_word,
  input  logic                          middle_write_en,
  input  logic [15:0]                   upper_word,
  input  logic                          upper_write_en,
  output instr_type                     instr_out,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = 80;

  logic [31:0]   lower_q,  lower_d;
  logic [31:0]   middle_q, middle_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          push_c, pop_c;
  logic [IW-1:0] commit_word_c;

  logic [IW-1:0] mem [FIFO_DEPTH];

  // Status derived from registered count only
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign instr_valid = ~empty;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign instr_out   = empty ? INIT_INSTR : bit_to_instr(mem[rd_ptr_q]);

  // Next-state: staging bypass, push/pop decisions, pointer and count updates
  always_comb begin
    lower_d       = lower_q;
    middle_d      = middle_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    push_c        = 1'b0;
    pop_c         = 1'b0;

    if (lower_write_en)  lower_d  = lower_word;
    if (middle_write_en) middle_d = middle_word;
    commit_word_c = {upper_word, middle_d, lower_d};

    push_c = upper_write_en & ~full;
    pop_c  = instr_ready & ~empty;
    if (upper_write_en && full) overflow_d = 1'b1;

    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lower_q    <= '0;
      middle_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      lower_q    <= lower_d;
      middle_q   <= middle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are don't-care after reset since pointers/count clear
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= commit_word_c;
  end

endmodule
